// File: rtl/loop_ctrl_nested.sv
// loop_ctrl_nested
//   Walks a configurable perfect loop nest and emits one control event per
//   non-stalled cycle: init+enter, enter, iteration step (valid), exit, done.
//
//   Configuration: each cfg_loop_iter_v strobe stores one loop limit
//   (iterations minus one), outermost loop first. A program consumes the
//   stored nest, and completion clears it for the next configuration.
//
// Ports
//   clk               rising-edge clock
//   reset             synchronous, active-low reset
//   cfg_loop_iter_v   config write strobe (accepted only while idle, not full)
//   cfg_loop_iter     iteration count minus one for the loop being written
//   start             begin walking the configured nest (accepted only in idle)
//   stall             freezes all sequencing state and masks the strobes
//   loop_index        loop id qualified by the strobes
//   loop_index_valid  one iteration step of loop_index
//   loop_init         first cycle of a program
//   loop_enter        entry into loop_index
//   loop_exit         exit from loop_index
//   loop_ctrl_done    single-cycle completion pulse
//   busy              high from start acceptance through the done cycle
module loop_ctrl_nested #(
    parameter int LOOP_ID_W   = 5,
    parameter int LOOP_ITER_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_loop_iter_v,
    input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
    input  logic                   start,
    input  logic                   stall,
    output logic [LOOP_ID_W-1:0]   loop_index,
    output logic                   loop_index_valid,
    output logic                   loop_init,
    output logic                   loop_enter,
    output logic                   loop_exit,
    output logic                   loop_ctrl_done,
    output logic                   busy
);

    localparam int NUM_LOOPS = 1 << LOOP_ID_W;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ENTER,
        INNER,
        EXIT,
        STEP,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [LOOP_ITER_W-1:0] limit_mem [NUM_LOOPS];
    logic [LOOP_ITER_W-1:0] count_mem [NUM_LOOPS];

    // One extra bit so a completely full table (NUM_LOOPS entries) is
    // distinguishable from an empty one.
    logic [LOOP_ID_W:0]   wr_ptr;
    logic [LOOP_ID_W-1:0] cur;
    logic [LOOP_ID_W-1:0] last;
    logic [LOOP_ID_W-1:0] cur_inc;
    logic [LOOP_ID_W-1:0] cur_dec;
    logic                 cfg_wr_en;
    logic                 inner_last;
    logic                 outer_more;

    // With a full table the low bits of wr_ptr are zero, so the subtraction
    // wraps to NUM_LOOPS-1, which is the correct innermost loop id.
    assign last    = wr_ptr[LOOP_ID_W-1:0] - LOOP_ID_W'(1);
    assign cur_inc = cur + LOOP_ID_W'(1);
    assign cur_dec = cur - LOOP_ID_W'(1);

    assign cfg_wr_en  = reset && (state == IDLE) && cfg_loop_iter_v && !wr_ptr[LOOP_ID_W];
    assign inner_last = (count_mem[last] == limit_mem[last]);
    // Evaluated while exiting loop cur: does the enclosing loop have
    // iterations left?
    assign outer_more = (count_mem[cur_dec] < limit_mem[cur_dec]);

    // Limit storage needs no reset: wr_ptr defines which entries are live.
    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            limit_mem[wr_ptr[LOOP_ID_W-1:0]] <= cfg_loop_iter;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        loop_index       = '0;
        loop_index_valid = 1'b0;
        loop_init        = 1'b0;
        loop_enter       = 1'b0;
        loop_exit        = 1'b0;
        loop_ctrl_done   = 1'b0;
        busy             = (state != IDLE);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (wr_ptr != '0) ? INIT : DONE;
                end
            end
            INIT: begin
                loop_init  = 1'b1;
                loop_enter = 1'b1;
                state_nx   = (last != '0) ? ENTER : INNER;
            end
            ENTER: begin
                loop_enter = 1'b1;
                loop_index = cur_inc;
                state_nx   = (cur_inc == last) ? INNER : ENTER;
            end
            INNER: begin
                loop_index_valid = 1'b1;
                loop_index       = last;
                state_nx         = inner_last ? EXIT : INNER;
            end
            EXIT: begin
                loop_exit  = 1'b1;
                loop_index = cur;
                if (cur == '0) begin
                    state_nx = DONE;
                end else begin
                    state_nx = outer_more ? STEP : EXIT;
                end
            end
            STEP: begin
                loop_index_valid = 1'b1;
                loop_index       = cur;
                state_nx         = ENTER;
            end
            DONE: begin
                loop_ctrl_done = 1'b1;
                state_nx       = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Stall freezes the walk in place; loop_index keeps its decoded value
        // because the state it is decoded from does not move.
        if (stall) begin
            state_nx         = state;
            loop_index_valid = 1'b0;
            loop_init        = 1'b0;
            loop_enter       = 1'b0;
            loop_exit        = 1'b0;
            loop_ctrl_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            cur    <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                count_mem[i] <= '0;
            end
        end else begin
            if (cfg_wr_en) begin
                wr_ptr <= wr_ptr + (LOOP_ID_W + 1)'(1);
            end
            if (!stall) begin
                case (state)
                    INIT: begin
                        cur <= '0;
                        for (int i = 0; i < NUM_LOOPS; i++) begin
                            count_mem[i] <= '0;
                        end
                    end
                    ENTER: begin
                        cur <= cur_inc;
                    end
                    INNER: begin
                        // The value after the final iteration is never
                        // observed: the following EXIT clears this entry.
                        count_mem[last] <= count_mem[last] + LOOP_ITER_W'(1);
                    end
                    EXIT: begin
                        count_mem[cur] <= '0;
                        if (cur != '0) begin
                            cur <= cur_dec;
                        end
                    end
                    STEP: begin
                        count_mem[cur] <= count_mem[cur] + LOOP_ITER_W'(1);
                    end
                    DONE: begin
                        wr_ptr <= '0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_loop_ctrl_nested.sv
// Self-checking bench for loop_ctrl_nested: directed cycle tables for the
// worked scenarios plus randomized nests compared against an event-list
// model of nested-loop execution.
module tb_loop_ctrl_nested;

    localparam int ID_W   = 5;
    localparam int ITER_W = 4;
    localparam logic [10:0] STALL_MASK = 11'b100_0001_1111;

    logic              clk;
    logic              reset;
    logic              cfg_loop_iter_v;
    logic [ITER_W-1:0] cfg_loop_iter;
    logic              start;
    logic              stall;
    logic [ID_W-1:0]   loop_index;
    logic              loop_index_valid;
    logic              loop_init;
    logic              loop_enter;
    logic              loop_exit;
    logic              loop_ctrl_done;
    logic              busy;
    logic [10:0]       obs;

    loop_ctrl_nested #(
        .LOOP_ID_W  (ID_W),
        .LOOP_ITER_W(ITER_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_loop_iter_v (cfg_loop_iter_v),
        .cfg_loop_iter   (cfg_loop_iter),
        .start           (start),
        .stall           (stall),
        .loop_index      (loop_index),
        .loop_index_valid(loop_index_valid),
        .loop_init       (loop_init),
        .loop_enter      (loop_enter),
        .loop_exit       (loop_exit),
        .loop_ctrl_done  (loop_ctrl_done),
        .busy            (busy)
    );

    assign obs = {busy, loop_init, loop_enter, loop_index_valid, loop_exit, loop_ctrl_done, loop_index};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              rst_n;
        logic              stl;
        logic              cfg_v;
        logic              st;
        logic [ITER_W-1:0] cfg;
        logic [10:0]       exp;
    } vec_t;

    vec_t        vecs [32];
    logic [10:0] e032 [15];
    logic [10:0] evq [$];
    int          lims [$];
    int          vcount [32];
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [10:0] mk(bit b, bit i, bit e, bit v, bit x, bit d, int idx);
        return {b, i, e, v, x, d, idx[4:0]};
    endfunction

    task automatic chk(string nm, logic [10:0] act, logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {busy,init,enter,valid,exit,done,idx}=%b required %b", nm, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic setv(int i, logic [10:0] e, logic s, logic cv, logic st, logic rn, logic [ITER_W-1:0] c);
        vecs[i].exp   = e;
        vecs[i].stl   = s;
        vecs[i].cfg_v = cv;
        vecs[i].st    = st;
        vecs[i].rst_n = rn;
        vecs[i].cfg   = c;
    endtask

    task automatic cfg_write(int v);
        cfg_loop_iter   = ITER_W'(v);
        cfg_loop_iter_v = 1'b1;
        @(posedge clk);
        #1;
        cfg_loop_iter_v = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_table(string nm, int n);
        for (int i = 0; i < n; i++) begin
            reset           = vecs[i].rst_n;
            stall           = vecs[i].stl;
            cfg_loop_iter_v = vecs[i].cfg_v;
            start           = vecs[i].st;
            cfg_loop_iter   = vecs[i].cfg;
            @(negedge clk);
            chk($sformatf("%s_c%0d", nm, i + 1), obs, vecs[i].exp);
            @(posedge clk);
            #1;
        end
        reset           = 1'b1;
        stall           = 1'b0;
        cfg_loop_iter_v = 1'b0;
        start           = 1'b0;
    endtask

    // Expected event list of a perfect loop nest: the first pass enters every
    // loop; after the innermost loop's iterations, loops are exited from the
    // inside out until one with iterations left takes its next step and the
    // deeper loops are entered afresh.
    function automatic void build_model();
        int cnt [32];
        int n;
        int last;
        int d;
        bit inner;
        evq.delete();
        n = lims.size();
        if (n == 0) begin
            evq.push_back(mk(1, 0, 0, 0, 0, 1, 0));
            return;
        end
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        last = n - 1;
        evq.push_back(mk(1, 1, 1, 0, 0, 0, 0));
        for (int i = 1; i <= last; i++) evq.push_back(mk(1, 0, 1, 0, 0, 0, i));
        inner = 1;
        d     = last;
        while (1) begin
            if (inner) begin
                for (int j = 0; j <= lims[last]; j++) evq.push_back(mk(1, 0, 0, 1, 0, 0, last));
                inner = 0;
                d     = last;
            end
            evq.push_back(mk(1, 0, 0, 0, 1, 0, d));
            cnt[d] = 0;
            if (d == 0) begin
                evq.push_back(mk(1, 0, 0, 0, 0, 1, 0));
                break;
            end
            if (cnt[d-1] < lims[d-1]) begin
                cnt[d-1]++;
                evq.push_back(mk(1, 0, 0, 1, 0, 0, d - 1));
                for (int i = d; i <= last; i++) evq.push_back(mk(1, 0, 1, 0, 0, 0, i));
                inner = 1;
            end else begin
                d--;
            end
        end
    endfunction

    // Called one cycle after start was sampled; consumes the model's events,
    // holding the current one while stall is high.
    task automatic run_model(string nm, bit rnd_stall);
        int guard;
        logic [10:0] o;
        build_model();
        guard = 0;
        while (evq.size() > 0 && guard < 5000) begin
            stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            o = obs;
            if (o[7]) vcount[o[4:0]]++;
            if (stall) begin
                chk({nm, "_stall"}, o, evq[0] & STALL_MASK);
            end else begin
                chk(nm, o, evq[0]);
                void'(evq.pop_front());
            end
            @(posedge clk);
            #1;
            guard++;
        end
        stall = 1'b0;
        if (evq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d events left, required 0", nm, evq.size());
        end
        @(negedge clk);
        chk({nm, "_idle"}, obs, 11'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic config_lims();
        for (int i = 0; i < lims.size(); i++) cfg_write(lims[i]);
    endtask

    initial begin
        int n;
        reset           = 1'b0;
        cfg_loop_iter_v = 1'b0;
        cfg_loop_iter   = '0;
        start           = 1'b0;
        stall           = 1'b0;

        // Reference traces for the two-deep {1,2} nest, cycles c1..c15.
        e032[0]  = mk(1, 1, 1, 0, 0, 0, 0);
        e032[1]  = mk(1, 0, 1, 0, 0, 0, 1);
        e032[2]  = mk(1, 0, 0, 1, 0, 0, 1);
        e032[3]  = mk(1, 0, 0, 1, 0, 0, 1);
        e032[4]  = mk(1, 0, 0, 1, 0, 0, 1);
        e032[5]  = mk(1, 0, 0, 0, 1, 0, 1);
        e032[6]  = mk(1, 0, 0, 1, 0, 0, 0);
        e032[7]  = mk(1, 0, 1, 0, 0, 0, 1);
        e032[8]  = mk(1, 0, 0, 1, 0, 0, 1);
        e032[9]  = mk(1, 0, 0, 1, 0, 0, 1);
        e032[10] = mk(1, 0, 0, 1, 0, 0, 1);
        e032[11] = mk(1, 0, 0, 0, 1, 0, 1);
        e032[12] = mk(1, 0, 0, 0, 1, 0, 0);
        e032[13] = mk(1, 0, 0, 0, 0, 1, 0);
        e032[14] = 11'd0;

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_state", obs, 11'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", obs, 11'd0);
        @(posedge clk);
        #1;

        // Two-deep nest, cycle-exact.
        cfg_write(1);
        cfg_write(2);
        start_pulse();
        for (int i = 0; i < 15; i++) setv(i, e032[i], 0, 0, 0, 1, 0);
        run_table("nest12", 15);

        // Same nest with stall held over c4..c6.
        cfg_write(1);
        cfg_write(2);
        start_pulse();
        n = 0;
        for (int i = 0; i < 3; i++) begin setv(n, e032[i], 0, 0, 0, 1, 0); n++; end
        for (int i = 0; i < 3; i++) begin setv(n, mk(1, 0, 0, 0, 0, 0, 1), 1, 0, 0, 1, 0); n++; end
        for (int i = 3; i < 15; i++) begin setv(n, e032[i], 0, 0, 0, 1, 0); n++; end
        run_table("nest12_stall", n);

        // Single loop, one iteration.
        lims = '{0};
        config_lims();
        start_pulse();
        run_model("single0", 0);

        // Empty nest, twice without reconfiguration.
        lims.delete();
        start_pulse();
        run_model("empty1", 0);
        start_pulse();
        run_model("empty2", 0);

        // Write and start while busy, then reset mid-program; first cycle
        // after release takes a fresh config.
        cfg_write(1);
        cfg_write(2);
        start_pulse();
        for (int i = 0; i < 8; i++) setv(i, e032[i], 0, 0, 0, 1, 0);
        setv(2, e032[2], 0, 1, 1, 1, 7);
        setv(7, e032[7], 0, 0, 0, 0, 0);
        setv(8, 11'd0, 0, 1, 0, 1, 2);
        run_table("busy_reset", 9);
        lims = '{2};
        start_pulse();
        run_model("after_reset", 0);

        // Table overflow: 33 writes, only the first 32 are kept.
        lims.delete();
        lims.push_back(1);
        for (int i = 1; i < 32; i++) lims.push_back(0);
        config_lims();
        cfg_write(0);
        start_pulse();
        run_model("full32", 0);

        // Three-deep {1,1,1}: 8 innermost steps, 2 middle, 1 outer.
        lims = '{1, 1, 1};
        config_lims();
        for (int i = 0; i < 32; i++) vcount[i] = 0;
        start_pulse();
        run_model("nest111", 0);
        chk_int("nest111_inner_valids", vcount[2], 8);
        chk_int("nest111_mid_valids", vcount[1], 2);
        chk_int("nest111_outer_valids", vcount[0], 1);

        // All-ones limits: full counter range without disturbing neighbours.
        lims = '{1, 15};
        config_lims();
        for (int i = 0; i < 32; i++) vcount[i] = 0;
        start_pulse();
        run_model("allones", 0);
        chk_int("allones_inner_valids", vcount[1], 32);

        // Randomized nests with random stalls.
        for (int t = 0; t < 30; t++) begin
            lims.delete();
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++) lims.push_back($urandom_range(0, 3));
            config_lims();
            start_pulse();
            run_model($sformatf("rand%0d", t), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/loop_ctrl_nested.md
LOOP_CTRL_NESTED -- requirements
Module: loop_ctrl_nested

Interface
REQ-001 SHALL have parameter LOOP_ID_W, default 5, width of loop index (max 2^LOOP_ID_W loops).
REQ-002 SHALL have parameter LOOP_ITER_W, default 16, width of per-loop iteration limit.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cfg_loop_iter_v  input  1  config write strobe; one loop per strobe, outermost first.
REQ-006 SHALL have port cfg_loop_iter  input  LOOP_ITER_W  iteration count minus one for the loop being written.
REQ-007 SHALL have port start  input  1  begin walking the configured nest.
REQ-008 SHALL have port stall  input  1  freeze sequencing while high.
REQ-009 SHALL have port loop_index  output  LOOP_ID_W  loop id qualified by the strobes below.
REQ-010 SHALL have port loop_index_valid  output  1  one iteration step of loop_index.
REQ-011 SHALL have port loop_init  output  1  first cycle of a program.
REQ-012 SHALL have port loop_enter  output  1  entry into loop_index.
REQ-013 SHALL have port loop_exit  output  1  exit from loop_index.
REQ-014 SHALL have port loop_ctrl_done  output  1  single-cycle completion pulse.
REQ-015 SHALL have port busy  output  1  high from start acceptance through the loop_ctrl_done cycle.

Function
REQ-016 SHALL store limits in a 2^LOOP_ID_W-entry array at wr_ptr, incrementing wr_ptr; num_loops = wr_ptr.
REQ-017 SHALL ignore cfg_loop_iter_v while busy or when wr_ptr has already reached 2^LOOP_ID_W entries (no wrap).
REQ-018 SHALL use states IDLE, INIT, ENTER, INNER, EXIT, STEP, DONE; last = num_loops-1; cur = current loop id.
REQ-019 IDLE: start with num_loops>0 -> INIT; start with num_loops==0 -> DONE; start ignored when not IDLE.
REQ-020 INIT (1 cycle): loop_init=1, loop_enter=1, loop_index=0, all counters cleared, cur=0; next ENTER if last>0, else INNER.
REQ-021 ENTER: cur+=1, loop_enter=1, loop_index=cur (new value); stay in ENTER until cur==last, then INNER.
REQ-022 INNER: loop_index_valid=1, loop_index=last each cycle; counter[last] increments; the cycle with counter==limit is the last valid, then EXIT.
REQ-023 EXIT: loop_exit=1, loop_index=cur, counter[cur] cleared; if cur==0 -> DONE; else cur-=1 and: counter[cur]<limit -> STEP, else EXIT again.
REQ-024 STEP: loop_index_valid=1, loop_index=cur, counter[cur] increments; next ENTER.
REQ-025 DONE (1 cycle): loop_ctrl_done=1, wr_ptr and num_loops cleared; next IDLE.
REQ-026 Exactly one of {init/enter, enter, valid, exit, done} events per non-stalled cycle; all strobes 0 in IDLE.
REQ-027 stall=1: state, cur, counters hold; all strobes 0; loop_index holds; busy unchanged; takes effect same cycle.
REQ-028 Counters LOOP_ITER_W bits; limit all-ones gives 2^LOOP_ITER_W iterations with no overflow into adjacent loop.
REQ-029 Outputs registered-state decoded; strobe latency from start acceptance to loop_init = 1 cycle.

Reset
REQ-030 reset==0 at a clock edge SHALL force IDLE, cur=0, wr_ptr=0, counters 0, all outputs 0 including loop_index and busy, including mid-program.
REQ-031 First cycle after reset release SHALL accept cfg_loop_iter_v and start normally.

Verification
REQ-032 Config {1,2}, start at c0 -> c1 init+enter idx0; c2 enter idx1; c3-5 valid idx1; c6 exit idx1; c7 valid idx0; c8 enter idx1; c9-11 valid idx1; c12 exit idx1; c13 exit idx0; c14 done; busy c1-c14.
REQ-033 Config {0}, start -> init+enter idx0, one valid idx0, exit idx0, done; 4 cycles total.
REQ-034 Start with no config -> loop_ctrl_done next cycle, no other strobes; second start after done with no reconfig -> same.
REQ-035 Scenario REQ-032 with stall high c4-c6 -> identical strobe sequence shifted 3 cycles, zero strobes during stall.
REQ-036 Config write and extra start during busy, then reset low at c8 of REQ-032 -> ignored writes/start; all outputs 0 next cycle; fresh config {2} runs 3 valids.
REQ-037 Config 33 strobes with LOOP_ID_W=5 -> only 32 stored; 3-deep nest {1,1,1} yields 8 innermost valids and 1+2 outer step valids.
